// File: rtl/ciu_dispatch_if.sv
// ciu_dispatch_if -- bundle of every non-clock signal between the issue stage,
// its requester and the Custom_Instruction_Unit.
//
// Request side : in_valid/in_ready handshake carrying in_opcode, in_r1, in_r2,
//                plus a queue-wide flush.
// CIU side     : ciu_opcode/ciu_r1/ciu_r2 toward the CIU, ciu_result back.
// Status       : mac_valid/mac_data result strobe, busy, illegal_cnt.
//
// Modports:
//   slave  -- the dispatch block itself.
//   master -- everything around it (requester + CIU).
interface ciu_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [18:0] in_r1;
  logic [18:0] in_r2;
  logic        flush;
  logic [3:0]  ciu_opcode;
  logic [18:0] ciu_r1;
  logic [18:0] ciu_r2;
  logic [18:0] ciu_result;
  logic        mac_valid;
  logic [18:0] mac_data;
  logic        busy;
  logic [7:0]  illegal_cnt;

  modport slave (
    input  in_valid, in_opcode, in_r1, in_r2, flush, ciu_result,
    output in_ready, ciu_opcode, ciu_r1, ciu_r2, mac_valid, mac_data,
           busy, illegal_cnt
  );

  modport master (
    output in_valid, in_opcode, in_r1, in_r2, flush, ciu_result,
    input  in_ready, ciu_opcode, ciu_r1, ciu_r2, mac_valid, mac_data,
           busy, illegal_cnt
  );
endinterface

// File: rtl/ciu_dispatch.sv
// ciu_dispatch -- issue stage in front of the Custom_Instruction_Unit.
//
// Queues custom-instruction requests {opcode, r1, r2} in a DEPTH-entry FIFO and
// presents each one to the CIU for exactly one clock, driving NOP (0000) in
// every other cycle. ISSUE_GAP NOP cycles are forced after each issue. When a
// MAC (0110) is issued, a two-stage tag pipe follows it so the CIU result is
// captured one edge after the CIU executes and reported with a one-cycle
// mac_valid strobe.
//
// Ports:
//   clk  -- rising-edge clock
//   rst  -- synchronous, active-high reset
//   bus  -- ciu_dispatch_if.slave: request handshake, flush, CIU drive and
//           result, mac_valid/mac_data, busy, illegal_cnt
//
// Parameters:
//   DEPTH     -- FIFO entries, power of two, 2..16
//   ISSUE_GAP -- NOP cycles forced between consecutive issues, 0..15
//
// Build option:
//   CIU_DISPATCH_ILLEGAL_CNT_EN -- when defined, illegal_cnt counts dropped
//   illegal opcodes (saturating at 255); otherwise it is tied to zero.
//   Illegal opcodes are accepted and discarded in both builds.
module ciu_dispatch #(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 0
) (
  input  logic           clk,
  input  logic           rst,
  ciu_dispatch_if.slave  bus
);

  localparam int DATA_W = 19;
  localparam int OP_W   = 4;
  localparam int ENT_W  = OP_W + 2 * DATA_W;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_MAC = 4'b0110;

  // Gap counter preload: counts down to zero over ISSUE_GAP cycles.
  localparam logic [3:0] GAP_LOAD = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        gap_cnt;
  logic              issue;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [ENT_W-1:0]  head;
  logic              empty;
  logic              full;
  logic              accept;
  logic              legal;
  logic              push;
  logic              can_issue;

  logic              mac_vld_p0;
  logic              mac_vld_p1;

  // Legal custom opcodes are 0001..0111: non-zero with the MSB clear.
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && !op[OP_W-1];
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign accept = bus.in_valid && !full;
  assign legal  = is_legal(bus.in_opcode);
  // Flush beats a simultaneous accept: the request is taken but dropped.
  assign push   = accept && legal && !bus.flush;

  assign head   = mem[rd_ptr[AW-1:0]];

  // Issue decisions look only at the registered FIFO state, so a request
  // accepted this edge is first eligible to issue on the next one.
  assign can_issue = !empty && !bus.flush;

  assign bus.in_ready = !full;
  assign bus.busy     = !empty || (state == S_ISSUE) ||
                        mac_vld_p0 || mac_vld_p1 || bus.mac_valid;

  // state names what the ciu_* registers are showing in the current cycle
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_issue) begin
          next_state = S_ISSUE;
          issue      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ISSUE_GAP > 0) begin
          next_state = S_GAP;
        end else if (can_issue) begin
          next_state = S_ISSUE;
          issue      = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (can_issue) begin
            next_state = S_ISSUE;
            issue      = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= 4'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_GAP && state != S_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == S_GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + (AW+1)'(1);
        if (issue) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.in_opcode, bus.in_r1, bus.in_r2};
    end
  end

  // ---- stage p0: CIU drive registers and MAC tag launch ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ciu_opcode <= OP_NOP;
      bus.ciu_r1     <= '0;
      bus.ciu_r2     <= '0;
      mac_vld_p0     <= 1'b0;
    end else begin
      mac_vld_p0 <= issue && (head[ENT_W-1 -: OP_W] == OP_MAC);
      if (issue) begin
        bus.ciu_opcode <= head[ENT_W-1 -: OP_W];
        bus.ciu_r1     <= head[2*DATA_W-1 -: DATA_W];
        bus.ciu_r2     <= head[DATA_W-1:0];
      end else begin
        // Operands hold so the CIU inputs toggle only on a real issue.
        bus.ciu_opcode <= OP_NOP;
      end
    end
  end

  // ---- stage p1: CIU executes; tag waits for the result to settle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_vld_p1 <= 1'b0;
    end else begin
      mac_vld_p1 <= mac_vld_p0;
    end
  end

  // ---- stage p2: capture the accumulator and strobe mac_valid ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mac_valid <= 1'b0;
      bus.mac_data  <= '0;
    end else begin
      bus.mac_valid <= mac_vld_p1;
      if (mac_vld_p1) begin
        bus.mac_data <= bus.ciu_result;
      end
    end
  end

`ifdef CIU_DISPATCH_ILLEGAL_CNT_EN
  logic [7:0] illegal_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Illegal requests are counted even when a flush drops them.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 8'd0;
    end else if (accept && !legal) begin
      illegal_q <= sat_inc8(illegal_q);
    end
  end

  assign bus.illegal_cnt = illegal_q;
`else
  assign bus.illegal_cnt = 8'd0;
`endif

endmodule
